// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul_engine slice.
package matmul_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    GAP,
    WRITE,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Wide enough to hold INNER full-scale products without overflow.
  function automatic int acc_width(input int size, input int inner);
    return 2 * size + clog2(inner);
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Memory-facing bus of matmul_engine: start/busy/done handshake plus A, B read and C write ports.
interface matmul_if #(
  parameter int SIZE   = 8,
  parameter int C_SIZE = 16
);

  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          a_read;
  logic [matmul_pkg::ADDR_W-1:0] a_read_address;
  logic [SIZE-1:0]               a_data;
  logic                          b_read;
  logic [matmul_pkg::ADDR_W-1:0] b_read_address;
  logic [SIZE-1:0]               b_data;
  logic                          c_write;
  logic [matmul_pkg::ADDR_W-1:0] c_write_address;
  logic [C_SIZE-1:0]             c_write_value;

  modport master (
    input  start, a_data, b_data,
    output busy, done, a_read, a_read_address, b_read, b_read_address,
           c_write, c_write_address, c_write_value
  );

  modport slave (
    output start, a_data, b_data,
    input  busy, done, a_read, a_read_address, b_read, b_read_address,
           c_write, c_write_address, c_write_value
  );

endinterface

// File: rtl/matmul_mac.sv
// Multiply-accumulate for one C element; result is truncated, or clamped when MATMUL_SAT_EN is defined.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int INNER  = 2,
  parameter int C_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [C_SIZE-1:0] result
);

  localparam int ACC_W = acc_width(SIZE, INNER);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;

  assign prod = ACC_W'(a) * ACC_W'(b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod : acc + prod;
    end
  end

  generate
    if (ACC_W > C_SIZE) begin : g_reduce
`ifdef MATMUL_SAT_EN
      assign result = (|acc[ACC_W-1:C_SIZE]) ? '1 : acc[C_SIZE-1:0];
`else
      assign result = acc[C_SIZE-1:0];
`endif
    end else begin : g_extend
      assign result = C_SIZE'(acc);
    end
  endgenerate

endmodule

// File: rtl/matmul_engine.sv
// Sequences reads of A and B, accumulates each C element and writes it out (C = A x B, unsigned, row-major).
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int ROW    = 2,
  parameter int INNER  = 2,
  parameter int COL    = 2,
  parameter int SIZE   = 8,
  parameter int C_SIZE = 16
) (
  input  logic     clk,
  input  logic     rst,
  matmul_if.master bus
);

  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROW - 1);
  localparam logic [ADDR_W-1:0] INNER_LAST = ADDR_W'(INNER - 1);
  localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(COL - 1);
  localparam logic [ADDR_W-1:0] INNER_A    = ADDR_W'(INNER);
  localparam logic [ADDR_W-1:0] COL_A      = ADDR_W'(COL);

  state_t              state;
  logic [ADDR_W-1:0]   i;
  logic [ADDR_W-1:0]   j;
  logic [ADDR_W-1:0]   k;
  logic [ADDR_W-1:0]   k_next;
  logic [ADDR_W-1:0]   i_next;
  logic [ADDR_W-1:0]   j_next;
  logic                last_k;
  logic                last_col;
  logic                last_row;
  logic [C_SIZE-1:0]   mac_result;

  assign last_k   = (k == INNER_LAST);
  assign last_col = (j == COL_LAST);
  assign last_row = (i == ROW_LAST);
  assign k_next   = k + 1'b1;
  assign j_next   = last_col ? '0 : j + 1'b1;
  assign i_next   = last_col ? i + 1'b1 : i;

  matmul_mac #(
    .SIZE   (SIZE),
    .INNER  (INNER),
    .C_SIZE (C_SIZE)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (state == FETCH),
    .load   (k == '0),
    .a      (bus.a_data),
    .b      (bus.b_data),
    .result (mac_result)
  );

  // Outputs are registered on entry to the state that owns them, so addresses
  // stay put while the strobes are low and the strobes form clean pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      i                   <= '0;
      j                   <= '0;
      k                   <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.a_read          <= 1'b0;
      bus.b_read          <= 1'b0;
      bus.a_read_address  <= '0;
      bus.b_read_address  <= '0;
      bus.c_write         <= 1'b0;
      bus.c_write_address <= '0;
      bus.c_write_value   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state              <= FETCH;
            i                  <= '0;
            j                  <= '0;
            k                  <= '0;
            bus.busy           <= 1'b1;
            bus.a_read         <= 1'b1;
            bus.b_read         <= 1'b1;
            bus.a_read_address <= '0;
            bus.b_read_address <= '0;
          end
        end
        FETCH: begin
          state      <= GAP;
          bus.a_read <= 1'b0;
          bus.b_read <= 1'b0;
        end
        GAP: begin
          if (last_k) begin
            state               <= WRITE;
            bus.c_write         <= 1'b1;
            bus.c_write_address <= i * COL_A + j;
            bus.c_write_value   <= mac_result;
          end else begin
            state              <= FETCH;
            k                  <= k_next;
            bus.a_read         <= 1'b1;
            bus.b_read         <= 1'b1;
            bus.a_read_address <= i * INNER_A + k_next;
            bus.b_read_address <= k_next * COL_A + j;
          end
        end
        WRITE: begin
          bus.c_write <= 1'b0;
          k           <= '0;
          if (last_col && last_row) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state              <= FETCH;
            i                  <= i_next;
            j                  <= j_next;
            bus.a_read         <= 1'b1;
            bus.b_read         <= 1'b1;
            bus.a_read_address <= i_next * INNER_A;
            bus.b_read_address <= j_next;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine against a cycle-level model of the C = A x B schedule.
// Expected C values follow MATMUL_SAT_EN: clamp when defined, truncate otherwise.
module tb_matmul_engine;

  localparam int ROW    = 2;
  localparam int INNER  = 2;
  localparam int COL    = 2;
  localparam int SIZE   = 8;
  localparam int C_SIZE = 16;
  localparam int PERIOD = 2 * INNER + 1;
  localparam int TOTAL  = ROW * COL * PERIOD;
`ifdef MATMUL_SAT_EN
  localparam int OVF_EXP = 65535;
`else
  localparam int OVF_EXP = 64514;
`endif

  logic clk;
  logic rst;
  logic clear_c;

  matmul_if #(.SIZE(SIZE), .C_SIZE(C_SIZE)) bus ();

  matmul_engine #(
    .ROW    (ROW),
    .INNER  (INNER),
    .COL    (COL),
    .SIZE   (SIZE),
    .C_SIZE (C_SIZE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [SIZE-1:0]   mem_a [ROW*INNER];
  logic [SIZE-1:0]   mem_b [INNER*COL];
  logic [C_SIZE-1:0] mem_c [ROW*COL];

  int     vectors;
  int     miscompares;
  bit     run;
  int     n;
  longint exp_c [ROW*COL];
  int     wr_count;
  int     done_count;
  int     done_n;
  int     rd_a [$];
  int     rd_b [$];
  int     exp_rd [16] = '{0, 0, 1, 2, 0, 1, 1, 3, 2, 0, 3, 2, 2, 1, 3, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memories refresh their read data only on a rising read strobe.
  always @(posedge bus.a_read) begin
    #1;
    bus.a_data = (bus.a_read_address < 32'(ROW*INNER)) ? mem_a[bus.a_read_address[1:0]] : '0;
  end

  always @(posedge bus.b_read) begin
    #1;
    bus.b_data = (bus.b_read_address < 32'(INNER*COL)) ? mem_b[bus.b_read_address[1:0]] : '0;
  end

  always @(posedge clk) begin
    if (clear_c) begin
      for (int x = 0; x < ROW*COL; x++) mem_c[x] <= 16'hDEAD;
    end else if (bus.c_write && bus.c_write_address < 32'(ROW*COL)) begin
      mem_c[bus.c_write_address[1:0]] <= bus.c_write_value;
    end
  end

  function automatic void compute_model();
    longint s;
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        s = 0;
        for (int q = 0; q < INNER; q++)
          s += longint'(mem_a[r*INNER+q]) * longint'(mem_b[q*COL+c]);
`ifdef MATMUL_SAT_EN
        exp_c[r*COL+c] = (s >= (longint'(1) << C_SIZE)) ? (longint'(1) << C_SIZE) - 1 : s;
`else
        exp_c[r*COL+c] = s % (longint'(1) << C_SIZE);
`endif
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_done"}, 32'(bus.done), 0);
    check_output({tag, "_a_read"}, 32'(bus.a_read), 0);
    check_output({tag, "_b_read"}, 32'(bus.b_read), 0);
    check_output({tag, "_c_write"}, 32'(bus.c_write), 0);
    check_output({tag, "_a_addr"}, bus.a_read_address, 0);
    check_output({tag, "_b_addr"}, bus.b_read_address, 0);
    check_output({tag, "_c_addr"}, bus.c_write_address, 0);
    check_output({tag, "_c_value"}, 32'(bus.c_write_value), 0);
  endtask

  // Per-cycle compare: cycle n of a run lies in element n/PERIOD, phase n%PERIOD;
  // even phases below 2*INNER are fetches of term phase/2, the last phase is the write.
  task automatic compare_cycle();
    int e, p, i, j, k;
    if (!rst) begin
      run = 0;
      check_all_zero("reset");
      return;
    end
    if (bus.done) done_count++;
    if (bus.c_write) wr_count++;
    if (bus.a_read) begin
      rd_a.push_back(int'(bus.a_read_address));
      rd_b.push_back(int'(bus.b_read_address));
    end
    if (run) begin
      if (n < TOTAL) begin
        e = n / PERIOD;
        p = n % PERIOD;
        i = e / COL;
        j = e % COL;
        k = (p == 2*INNER) ? INNER - 1 : p / 2;
        check_output("busy", 32'(bus.busy), 1);
        check_output("done", 32'(bus.done), 0);
        check_output("a_read", 32'(bus.a_read), 32'(p < 2*INNER && p % 2 == 0));
        check_output("b_read", 32'(bus.b_read), 32'(p < 2*INNER && p % 2 == 0));
        check_output("a_addr", bus.a_read_address, i*INNER + k);
        check_output("b_addr", bus.b_read_address, k*COL + j);
        check_output("c_write", 32'(bus.c_write), 32'(p == 2*INNER));
        if (p == 2*INNER) begin
          check_output("c_addr", bus.c_write_address, e);
          check_output("c_value", 32'(bus.c_write_value), 32'(exp_c[e]));
        end
      end else begin
        if (bus.done) done_n = n;
        check_output("done_pulse", 32'(bus.done), 1);
        check_output("done_busy", 32'(bus.busy), 0);
        check_output("done_a_read", 32'(bus.a_read), 0);
        check_output("done_c_write", 32'(bus.c_write), 0);
        check_output("done_c_addr_hold", bus.c_write_address, ROW*COL - 1);
        check_output("done_c_value_hold", 32'(bus.c_write_value), 32'(exp_c[ROW*COL-1]));
      end
      n++;
      if (n > TOTAL) run = 0;
    end else begin
      check_output("idle_busy", 32'(bus.busy), 0);
      check_output("idle_done", 32'(bus.done), 0);
      check_output("idle_a_read", 32'(bus.a_read), 0);
      check_output("idle_b_read", 32'(bus.b_read), 0);
      check_output("idle_c_write", 32'(bus.c_write), 0);
      if (bus.start) begin
        run    = 1;
        n      = 0;
        done_n = -1;
        compute_model();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_c = 1'b1;
    tick();
    clear_c = 1'b0;
  endtask

  task automatic load_basic();
    for (int x = 0; x < 4; x++) begin
      mem_a[x] = SIZE'(x + 1);
      mem_b[x] = SIZE'(x + 5);
    end
  endtask

  // One full pass; optionally re-pulses start mid-run and/or during the done cycle.
  task automatic apply_stimulus(input int busy_pulse_at, input bit pulse_in_done);
    bit seen;
    seen = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 200 && !seen; c++) begin
      bus.start = (c == busy_pulse_at);
      tick();
      if (bus.done) seen = 1;
    end
    bus.start = pulse_in_done;
    tick();
    bus.start = 1'b0;
    if (!seen) check_output("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, w0, d0;
    vectors     = 0;
    miscompares = 0;
    run         = 0;
    n           = 0;
    wr_count    = 0;
    done_count  = 0;
    done_n      = -1;
    rst         = 1'b0;
    clear_c     = 1'b0;
    bus.start   = 1'b0;
    for (int x = 0; x < ROW*COL; x++) exp_c[x] = 0;

    tick();
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] basic multiply");
    load_basic();
    pulse_clear();
    r0 = rd_a.size();
    apply_stimulus(0, 0);
    check_output("basic_c0", 32'(mem_c[0]), 19);
    check_output("basic_c1", 32'(mem_c[1]), 22);
    check_output("basic_c2", 32'(mem_c[2]), 43);
    check_output("basic_c3", 32'(mem_c[3]), 50);
    check_output("basic_done_latency", done_n, 20);
    check_output("strobe_count", rd_a.size() - r0, 8);
    for (int t = 0; t < 8; t++) begin
      if (r0 + t < rd_a.size()) begin
        check_output("strobe_a_addr", rd_a[r0+t], exp_rd[2*t]);
        check_output("strobe_b_addr", rd_b[r0+t], exp_rd[2*t+1]);
      end
    end

    $display("[TB] overflow");
    for (int x = 0; x < 4; x++) begin
      mem_a[x] = 8'hFF;
      mem_b[x] = 8'hFF;
    end
    pulse_clear();
    apply_stimulus(0, 0);
    for (int x = 0; x < 4; x++) check_output("overflow_c", 32'(mem_c[x]), OVF_EXP);

    $display("[TB] start while busy and in done");
    load_basic();
    pulse_clear();
    w0 = wr_count;
    d0 = done_count;
    apply_stimulus(5, 0);
    repeat (3) tick();
    check_output("busy_start_writes", wr_count - w0, 4);
    check_output("busy_start_dones", done_count - d0, 1);
    w0 = wr_count;
    d0 = done_count;
    apply_stimulus(0, 1);
    repeat (4) tick();
    check_output("second_pass_writes", wr_count - w0, 4);
    check_output("second_pass_dones", done_count - d0, 1);
    check_output("second_pass_latency", done_n, 20);

    $display("[TB] mid-run reset");
    load_basic();
    pulse_clear();
    w0 = wr_count;
    d0 = done_count;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 60 && wr_count < w0 + 2; c++) tick();
    check_output("pre_reset_busy", 32'(bus.busy), 1);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) tick();
    check_output("reset_c0", 32'(mem_c[0]), 19);
    check_output("reset_c1", 32'(mem_c[1]), 22);
    check_output("reset_c2_untouched", 32'(mem_c[2]), 32'h0000DEAD);
    check_output("reset_no_done", done_count - d0, 0);
    rst = 1'b1;
    tick();
    d0 = done_count;
    apply_stimulus(0, 0);
    check_output("after_reset_c3", 32'(mem_c[3]), 50);
    check_output("after_reset_done", done_count - d0, 1);

    $display("[TB] zero operands");
    for (int x = 0; x < 4; x++) begin
      mem_a[x] = '0;
      mem_b[x] = SIZE'($urandom_range(0, 255));
    end
    pulse_clear();
    apply_stimulus(0, 0);
    for (int x = 0; x < 4; x++) check_output("zero_c", 32'(mem_c[x]), 0);
    check_output("zero_latency", done_n, 20);

    $display("[TB] random operands");
    for (int r = 0; r < 10; r++) begin
      for (int x = 0; x < 4; x++) begin
        mem_a[x] = SIZE'($urandom_range(0, 255));
        mem_b[x] = SIZE'($urandom_range(0, 255));
      end
      pulse_clear();
      apply_stimulus(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 19)) : 0,
                     1'($urandom_range(0, 1)));
      for (int x = 0; x < 4; x++) check_output("random_mem_c", 32'(mem_c[x]), 32'(exp_c[x]));
      check_output("random_latency", done_n, TOTAL);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
